// File: rtl/miriscv_irq_pkg.sv
// Shared types and constants for the miriscv interrupt controller.
package miriscv_irq_pkg;

  typedef enum logic {
    IRQ_IDLE   = 1'b0,
    IRQ_ACTIVE = 1'b1
  } irq_state_e;

  localparam int unsigned MCAUSE_INT_BIT = 31;
  localparam int unsigned MCAUSE_W       = 32;
  localparam int unsigned IRQ_ID_W       = 5;
  localparam int unsigned IRQ_MAX_NUM    = 32;

  // Interrupt-flagged mcause value for a channel id.
  function automatic logic [MCAUSE_W-1:0] irq_mcause(input logic [IRQ_ID_W-1:0] id);
    logic [MCAUSE_W-1:0] cause;
    cause                 = '0;
    cause[MCAUSE_INT_BIT] = 1'b1;
    cause[IRQ_ID_W-1:0]   = id;
    return cause;
  endfunction

endpackage

// File: rtl/miriscv_irq_arbiter.sv
// Combinational find-first over the eligible vector, fixed or rotating from ptr.
module miriscv_irq_arbiter
  import miriscv_irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 32
) (
  input  logic [NUM_IRQ-1:0]  eligible_i,
  input  logic [IRQ_ID_W-1:0] ptr_i,
  input  logic                rr_mode_i,
  output logic                valid_c,
  output logic [IRQ_ID_W-1:0] id_c
);

  logic [NUM_IRQ-1:0] rot;
  int unsigned        sh;
  int unsigned        sum;

  always_comb begin
    valid_c = 1'b0;
    id_c    = '0;
    sum     = 0;
    sh      = NUM_IRQ - 32'(ptr_i);
    // Rotate so that bit 0 of rot corresponds to channel ptr.
    if (rr_mode_i) begin
      rot = (eligible_i >> ptr_i) | (eligible_i << sh);
    end else begin
      rot = eligible_i;
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (rot[i] && !valid_c) begin
        valid_c = 1'b1;
        sum     = i;
      end
    end
    if (rr_mode_i) begin
      sum = sum + 32'(ptr_i);
      if (sum >= NUM_IRQ) begin
        sum = sum - NUM_IRQ;
      end
    end
    id_c = IRQ_ID_W'(sum);
  end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// Interrupt controller: edge/level pending capture, arbitration and a present/ack handshake.
module miriscv_irq_ctrl
  import miriscv_irq_pkg::*;
#(
  parameter int unsigned        NUM_IRQ   = 32,
  parameter int unsigned        PRIO_MODE = 0,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [NUM_IRQ-1:0]  irq_req_i,
  input  logic [NUM_IRQ-1:0]  irq_mie_i,
  input  logic                irq_ack_i,
  output logic                irq_o,
  output logic [MCAUSE_W-1:0] irq_mcause_o,
  output logic [NUM_IRQ-1:0]  irq_pending_o
);

  irq_state_e          state_q, state_d;
  logic [NUM_IRQ-1:0]  req_q, req_d;
  logic [NUM_IRQ-1:0]  pend_q, pend_d;
  logic [NUM_IRQ-1:0]  eligible_c;
  logic [NUM_IRQ-1:0]  clr_c;
  logic [IRQ_ID_W-1:0] ptr_q, ptr_d;
  logic [IRQ_ID_W-1:0] arb_id_c;
  logic [IRQ_ID_W-1:0] cur_id_c;
  logic                arb_valid_c;
  logic [MCAUSE_W-1:0] mcause_q, mcause_d;
  logic                irq_q, irq_d;

  assign cur_id_c   = mcause_q[IRQ_ID_W-1:0];
  assign eligible_c = pend_q & irq_mie_i;

  miriscv_irq_arbiter #(
    .NUM_IRQ (NUM_IRQ)
  ) u_arbiter (
    .eligible_i (eligible_c),
    .ptr_i      (ptr_q),
    .rr_mode_i  (PRIO_MODE == 32'd1),
    .valid_c    (arb_valid_c),
    .id_c       (arb_id_c)
  );

  // Pending capture; a new edge beats a same-cycle ack clear.
  always_comb begin
    req_d = irq_req_i;
    clr_c = '0;
    if (state_q == IRQ_ACTIVE && irq_ack_i) begin
      clr_c = NUM_IRQ'(1) << cur_id_c;
    end
    pend_d = (EDGE_MASK & ((pend_q & ~clr_c) | (irq_req_i & ~req_q)))
           | (~EDGE_MASK & req_q);
  end

  // Handshake FSM: present one interrupt and freeze it until acknowledged.
  always_comb begin
    state_d  = state_q;
    mcause_d = mcause_q;
    ptr_d    = ptr_q;
    case (state_q)
      IRQ_IDLE: begin
        if (arb_valid_c) begin
          state_d  = IRQ_ACTIVE;
          mcause_d = irq_mcause(arb_id_c);
        end
      end
      IRQ_ACTIVE: begin
        if (irq_ack_i) begin
          state_d = IRQ_IDLE;
          ptr_d   = (cur_id_c == IRQ_ID_W'(NUM_IRQ - 1)) ? '0 : cur_id_c + IRQ_ID_W'(1);
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
    irq_d = (state_d == IRQ_ACTIVE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IRQ_IDLE;
      req_q    <= '0;
      pend_q   <= '0;
      ptr_q    <= '0;
      mcause_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      mcause_q <= mcause_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_o         = irq_q;
  assign irq_mcause_o  = mcause_q;
  assign irq_pending_o = pend_q;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Self-checking bench for miriscv_irq_ctrl with an expected-cause scoreboard.
module tb_miriscv_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req, mie;
  logic        ack;
  logic        irq;
  logic [31:0] mcause, pending;
  logic [3:0]  req4, mie4;
  logic        ack4;
  logic        irq_rr, irq_fx;
  logic [31:0] mc_rr, mc_fx;
  logic [3:0]  pend_rr, pend_fx;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_rr[$];
  logic [31:0] exp_fx[$];

  always #5 clk = ~clk;

  miriscv_irq_ctrl #(.NUM_IRQ(32), .PRIO_MODE(0), .EDGE_MASK(32'h0000_0022)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .irq_req_i(req), .irq_mie_i(mie), .irq_ack_i(ack),
    .irq_o(irq), .irq_mcause_o(mcause), .irq_pending_o(pending));

  miriscv_irq_ctrl #(.NUM_IRQ(4), .PRIO_MODE(1), .EDGE_MASK(4'h0)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n), .irq_req_i(req4), .irq_mie_i(mie4), .irq_ack_i(ack4),
    .irq_o(irq_rr), .irq_mcause_o(mc_rr), .irq_pending_o(pend_rr));

  miriscv_irq_ctrl #(.NUM_IRQ(4), .PRIO_MODE(0), .EDGE_MASK(4'h0)) dut_fx (
    .clk_i(clk), .rst_n_i(rst_n), .irq_req_i(req4), .irq_mie_i(mie4), .irq_ack_i(ack4),
    .irq_o(irq_fx), .irq_mcause_o(mc_fx), .irq_pending_o(pend_fx));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = '0; mie = '0; ack = 1'b0;
    req4 = '0; mie4 = '0; ack4 = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic wait_irq(input int which, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick;
      if (((which == 0) ? irq : irq_rr) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (mcause !== 32'h0) begin bad++; $display("FAIL reset_mcause: got %h want 0", mcause); end
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL reset_pending: got %h want 0", pending); end
  endtask

  task automatic test_fixed_level;
    logic [31:0] e;
    do_reset;
    mie = '1;
    req[3] = 1'b1; req[7] = 1'b1;
    exp_q.push_back(32'h8000_0003);
    exp_q.push_back(32'h8000_0007);
    tick; tick;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_early: got %b want 0", irq); end
    tick;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_latency: got %b want 1", irq); end
    e = exp_q.pop_front();
    total++; if (mcause !== e) begin bad++; $display("FAIL lvl_first_cause: got %h want %h", mcause, e); end
    total++; if (pending !== 32'h88) begin bad++; $display("FAIL lvl_pending: got %h want 00000088", pending); end
    req[3] = 1'b0;
    tick; tick;
    total++; if (irq !== 1'b1 || mcause !== 32'h8000_0003) begin
      bad++; $display("FAIL lvl_hold: got irq=%b cause=%h want 1/80000003", irq, mcause); end
    ack = 1'b1; tick; ack = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_idle_gap: got %b want 0", irq); end
    tick;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL lvl_second_irq: got %b want 1", irq); end
    e = exp_q.pop_front();
    total++; if (mcause !== e) begin bad++; $display("FAIL lvl_second_cause: got %h want %h", mcause, e); end
    req[7] = 1'b0;
    tick; tick;
    ack = 1'b1; tick; ack = 1'b0;
    tick; tick;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL lvl_quiet: got %b want 0", irq); end
  endtask

  task automatic test_edge;
    logic [31:0] e;
    bit seen;
    do_reset;
    mie = '1;
    req[5] = 1'b1; tick; req[5] = 1'b0;
    total++; if (pending !== 32'h20) begin bad++; $display("FAIL edge_pending_set: got %h want 00000020", pending); end
    exp_q.push_back(32'h8000_0005);
    wait_irq(0, 4, seen);
    total++; if (!seen) begin bad++; $display("FAIL edge_irq_timeout: got irq=%b want 1", irq); end
    e = exp_q.pop_front();
    total++; if (mcause !== e) begin bad++; $display("FAIL edge_cause: got %h want %h", mcause, e); end
    ack = 1'b1; tick; ack = 1'b0;
    total++; if (pending !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL edge_ack_clear: got pend=%h irq=%b want 0/0", pending, irq); end
    repeat (4) tick;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL edge_no_rearm: got %b want 0", irq); end
    ack = 1'b1; tick; ack = 1'b0; tick;
    total++; if (irq !== 1'b0 || pending !== 32'h0 || mcause !== 32'h8000_0005) begin
      bad++; $display("FAIL stray_ack: got irq=%b pend=%h cause=%h want 0/0/80000005", irq, pending, mcause); end
  endtask

  task automatic test_round_robin;
    logic [31:0] e, ef;
    bit seen;
    do_reset;
    req4 = 4'hF; mie4 = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_rr.push_back(32'h8000_0000 | 32'(k % 4));
      exp_fx.push_back(32'h8000_0000);
    end
    for (int k = 0; k < 5; k++) begin
      wait_irq(1, 6, seen);
      total++; if (!seen) begin bad++; $display("FAIL rr_timeout_%0d: got irq=%b want 1", k, irq_rr); end
      e  = exp_rr.pop_front();
      ef = exp_fx.pop_front();
      total++; if (mc_rr !== e) begin bad++; $display("FAIL rr_cause_%0d: got %h want %h", k, mc_rr, e); end
      total++; if (irq_fx !== 1'b1 || mc_fx !== ef) begin
        bad++; $display("FAIL fixed4_cause_%0d: got irq=%b cause=%h want 1/%h", k, irq_fx, mc_fx, ef); end
      ack4 = 1'b1; tick; ack4 = 1'b0;
    end
  endtask

  task automatic test_mask_hold;
    logic [31:0] e;
    bit seen;
    do_reset;
    mie = '1; mie[2] = 1'b0;
    req[2] = 1'b1;
    exp_q.push_back(32'h8000_0002);
    repeat (5) tick;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_block: got %b want 0", irq); end
    mie[2] = 1'b1;
    wait_irq(0, 2, seen);
    total++; if (!seen) begin bad++; $display("FAIL mask_enable: got irq=%b want 1", irq); end
    e = exp_q.pop_front();
    total++; if (mcause !== e) begin bad++; $display("FAIL mask_cause: got %h want %h", mcause, e); end
    mie[2] = 1'b0; req[2] = 1'b0;
    repeat (3) tick;
    total++; if (irq !== 1'b1 || mcause !== 32'h8000_0002) begin
      bad++; $display("FAIL mask_hold: got irq=%b cause=%h want 1/80000002", irq, mcause); end
    ack = 1'b1; tick; ack = 1'b0; tick;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_after_ack: got %b want 0", irq); end
  endtask

  task automatic test_edge_ack_collision;
    logic [31:0] e;
    bit seen;
    do_reset;
    mie = '1;
    req[1] = 1'b1; tick; req[1] = 1'b0;
    exp_q.push_back(32'h8000_0001);
    exp_q.push_back(32'h8000_0001);
    wait_irq(0, 4, seen);
    total++; if (!seen) begin bad++; $display("FAIL coll_timeout: got irq=%b want 1", irq); end
    e = exp_q.pop_front();
    total++; if (mcause !== e) begin bad++; $display("FAIL coll_first_cause: got %h want %h", mcause, e); end
    ack = 1'b1; req[1] = 1'b1; tick; ack = 1'b0;
    total++; if (irq !== 1'b0 || pending[1] !== 1'b1) begin
      bad++; $display("FAIL coll_set_wins: got irq=%b pend1=%b want 0/1", irq, pending[1]); end
    tick;
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL coll_reassert: got %b want 1", irq); end
    e = exp_q.pop_front();
    total++; if (mcause !== e) begin bad++; $display("FAIL coll_second_cause: got %h want %h", mcause, e); end
    req[1] = 1'b0; ack = 1'b1; tick; ack = 1'b0;
    total++; if (pending !== 32'h0 || irq !== 1'b0) begin
      bad++; $display("FAIL coll_final_clear: got pend=%h irq=%b want 0/0", pending, irq); end
  endtask

  task automatic test_reset_active;
    logic [31:0] e;
    bit seen;
    do_reset;
    req4 = 4'hF; mie4 = 4'hF;
    mie = '1; req[9] = 1'b1;
    wait_irq(1, 6, seen);
    ack4 = 1'b1; tick; ack4 = 1'b0;
    wait_irq(1, 3, seen);
    total++; if (!seen || mc_rr !== 32'h8000_0001) begin
      bad++; $display("FAIL rst_pre_active: got irq=%b cause=%h want 1/80000001", irq_rr, mc_rr); end
    rst_n = 1'b0; tick;
    total++; if (irq_rr !== 1'b0 || mc_rr !== 32'h0 || pend_rr !== 4'h0) begin
      bad++; $display("FAIL rst_mid_rr: got irq=%b cause=%h pend=%h want 0/0/0", irq_rr, mc_rr, pend_rr); end
    total++; if (irq !== 1'b0 || mcause !== 32'h0 || pending !== 32'h0) begin
      bad++; $display("FAIL rst_mid_main: got irq=%b cause=%h pend=%h want 0/0/0", irq, mcause, pending); end
    rst_n = 1'b1;
    exp_rr.push_back(32'h8000_0000);
    wait_irq(1, 6, seen);
    total++; if (!seen) begin bad++; $display("FAIL rst_recover_timeout: got irq=%b want 1", irq_rr); end
    e = exp_rr.pop_front();
    total++; if (mc_rr !== e) begin bad++; $display("FAIL rst_ptr_zero: got %h want %h", mc_rr, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fixed_level;
    test_edge;
    test_round_robin;
    test_mask_hold;
    test_edge_ack_collision;
    test_reset_active;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
